// File: rtl/ntsc_sync_separator.sv
// Composite-sync separator: classifies sync pulses by width into H/V events and
// runs a line flywheel that keeps line timing through missing H pulses.
module ntsc_sync_separator #(
    parameter int H_TOTAL    = 228,
    parameter int H_MIN_PER  = 220,
    parameter int H_MAX_PER  = 236,
    parameter int HS_MIN_W   = 8,
    parameter int HS_MAX_W   = 40,
    parameter int VS_MIN_W   = 100,
    parameter int V_TOTAL    = 525,
    parameter int LOCK_LINES = 8,
    parameter int MISS_MAX   = 4
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic       sync_in,
    output logic       hsync_det,
    output logic       vsync_det,
    output logic       line_start,
    output logic [7:0] h_pos,
    output logic [9:0] line_count,
    output logic       locked,
    output logic       coast
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_COAST   = 2'd3;

    localparam logic [9:0] HS_MIN_C    = 10'(HS_MIN_W);
    localparam logic [9:0] HS_MAX_C    = 10'(HS_MAX_W);
    localparam logic [9:0] VS_PRE_C    = 10'(VS_MIN_W - 1);
    localparam logic [9:0] WIDTH_SAT_C = 10'h3FF;
    localparam logic [8:0] PER_MIN_C   = 9'(H_MIN_PER);
    localparam logic [8:0] PER_MAX_C   = 9'(H_MAX_PER);
    localparam logic [7:0] TIMEOUT_C   = 8'(H_MAX_PER);
    localparam logic [7:0] RELOAD_C    = 8'(H_MAX_PER + 1 - H_TOTAL);
    localparam logic [3:0] LOCK_C      = 4'(LOCK_LINES);
    localparam logic [2:0] MISS_LAST_C = 3'(MISS_MAX - 1);
    localparam logic [9:0] LINE_LAST_C = 10'(V_TOTAL - 1);

    logic       sync_q, armed_q, armed_d;
    logic [9:0] width_q, width_d;
    logic       hsync_det_q, hsync_det_d, vsync_det_q, vsync_det_d;
    logic [1:0] state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [2:0] miss_q, miss_d;
    logic [7:0] h_pos_q, h_pos_d;
    logic       line_start_q, line_start_d;
    logic [9:0] line_count_q, line_count_d;
    logic       locked_q, locked_d, coast_q, coast_d;
    logic [8:0] period_s;
    logic       period_ok_s, timeout_s;

    // Pulse-width measurement; counting is armed by the first low sample after reset.
    always_comb begin
        armed_d     = armed_q | ~sync_in;
        width_d     = 10'd0;
        hsync_det_d = 1'b0;
        vsync_det_d = 1'b0;
        if (armed_q && sync_q) begin
            if (width_q != WIDTH_SAT_C) begin
                width_d = width_q + 10'd1;
            end else begin
                width_d = width_q;
            end
            if (width_q == VS_PRE_C) begin
                vsync_det_d = 1'b1;
            end else begin
                vsync_det_d = 1'b0;
            end
        end else begin
            width_d = 10'd0;
            if ((width_q >= HS_MIN_C) && (width_q <= HS_MAX_C)) begin
                hsync_det_d = 1'b1;
            end else begin
                hsync_det_d = 1'b0;
            end
        end
    end

    assign period_s    = {1'b0, h_pos_q} + 9'd1;
    assign period_ok_s = (period_s >= PER_MIN_C) && (period_s <= PER_MAX_C);
    assign timeout_s   = (h_pos_q == TIMEOUT_C);

    // Line flywheel; a real hsync_det always takes priority over a timeout.
    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        miss_d       = miss_q;
        h_pos_d      = h_pos_q + 8'd1;
        line_start_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (hsync_det_q) begin
                    state_d = ST_ACQUIRE;
                    good_d  = 4'd0;
                    h_pos_d = 8'd0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_ACQUIRE: begin
                if (hsync_det_q) begin
                    h_pos_d = 8'd0;
                    if (!period_ok_s) begin
                        good_d = 4'd0;
                    end else if (good_q + 4'd1 == LOCK_C) begin
                        good_d       = 4'd0;
                        miss_d       = 3'd0;
                        state_d      = ST_LOCKED;
                        line_start_d = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else if (timeout_s) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (hsync_det_q && (period_s >= PER_MIN_C)) begin
                    line_start_d = 1'b1;
                    h_pos_d      = 8'd0;
                end else if (!hsync_det_q && timeout_s) begin
                    state_d      = ST_COAST;
                    miss_d       = 3'd1;
                    line_start_d = 1'b1;
                    h_pos_d      = RELOAD_C;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_COAST: begin
                if (hsync_det_q) begin
                    state_d      = ST_LOCKED;
                    miss_d       = 3'd0;
                    line_start_d = 1'b1;
                    h_pos_d      = 8'd0;
                end else if (timeout_s && (miss_q < MISS_LAST_C)) begin
                    miss_d       = miss_q + 3'd1;
                    line_start_d = 1'b1;
                    h_pos_d      = RELOAD_C;
                end else if (timeout_s) begin
                    state_d = ST_SEARCH;
                    miss_d  = 3'd0;
                end else begin
                    state_d = ST_COAST;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 4'd0;
                miss_d  = 3'd0;
            end
        endcase
    end

    // Line counter; a vertical event restarts the frame even over a line start.
    always_comb begin
        if (vsync_det_d) begin
            line_count_d = 10'd0;
        end else if (line_start_d) begin
            if (line_count_q == LINE_LAST_C) begin
                line_count_d = 10'd0;
            end else begin
                line_count_d = line_count_q + 10'd1;
            end
        end else begin
            line_count_d = line_count_q;
        end
        locked_d = (state_d == ST_LOCKED) || (state_d == ST_COAST);
        coast_d  = (state_d == ST_COAST);
    end

    // State and output registers.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            sync_q       <= 1'b0;
            armed_q      <= 1'b0;
            width_q      <= 10'd0;
            hsync_det_q  <= 1'b0;
            vsync_det_q  <= 1'b0;
            state_q      <= ST_SEARCH;
            good_q       <= 4'd0;
            miss_q       <= 3'd0;
            h_pos_q      <= 8'd0;
            line_start_q <= 1'b0;
            line_count_q <= 10'd0;
            locked_q     <= 1'b0;
            coast_q      <= 1'b0;
        end else begin
            sync_q       <= sync_in;
            armed_q      <= armed_d;
            width_q      <= width_d;
            hsync_det_q  <= hsync_det_d;
            vsync_det_q  <= vsync_det_d;
            state_q      <= state_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            h_pos_q      <= h_pos_d;
            line_start_q <= line_start_d;
            line_count_q <= line_count_d;
            locked_q     <= locked_d;
            coast_q      <= coast_d;
        end
    end

    assign hsync_det  = hsync_det_q;
    assign vsync_det  = vsync_det_q;
    assign line_start = line_start_q;
    assign h_pos      = h_pos_q;
    assign line_count = line_count_q;
    assign locked     = locked_q;
    assign coast      = coast_q;

endmodule
